// File: rtl/instr_decode_stage.sv
// Single-register instruction decode stage with valid/ready handshake.
// Define DECODE_SCOREBOARD_EN to add the busy-register scoreboard, hazard stall and stall counter.
module instr_decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  rr1,
    output logic [1:0]  rr2,
    output logic [1:0]  wr,
    output logic        regwrite,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic [15:0] imm,
    input  logic        wb_done,
    input  logic [1:0]  wb_reg,
    output logic [7:0]  stall_count
);
    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    assign op = instr[15:12];
    assign rs = instr[11:10];
    assign rt = instr[9:8];
    assign rd = instr[7:6];

    logic [1:0] d_rr1, d_rr2, d_wr;
    logic       d_regwrite, d_alu_src, d_mem_read, d_mem_write, d_branch;
    logic [2:0] d_alu_op;
    logic       use_rs, use_rt;
    logic       hazard;

    always_comb begin
        d_rr1 = 2'd0; d_rr2 = 2'd0; d_wr = 2'd0;
        d_regwrite = 1'b0; d_alu_op = 3'b000; d_alu_src = 1'b0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_branch = 1'b0;
        use_rs = 1'b0; use_rt = 1'b0;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
                d_rr1 = rs; d_rr2 = rt; d_wr = rd; d_regwrite = 1'b1;
                use_rs = 1'b1; use_rt = 1'b1;
                case (op)
                    4'b0000: d_alu_op = 3'b010;
                    4'b0001: d_alu_op = 3'b110;
                    4'b0010: d_alu_op = 3'b000;
                    4'b0011: d_alu_op = 3'b001;
                    default: d_alu_op = 3'b111;
                endcase
            end
            4'b0100, 4'b0101: begin
                d_rr1 = rs; d_wr = rt; d_regwrite = 1'b1; d_alu_src = 1'b1;
                d_alu_op = 3'b010; d_mem_read = op[0]; use_rs = 1'b1;
            end
            4'b0110: begin
                d_rr1 = rs; d_rr2 = rt; d_mem_write = 1'b1; d_alu_src = 1'b1;
                d_alu_op = 3'b010; use_rs = 1'b1; use_rt = 1'b1;
            end
            4'b1000: begin
                d_rr1 = rs; d_rr2 = rt; d_branch = 1'b1; d_alu_op = 3'b110;
                use_rs = 1'b1; use_rt = 1'b1;
            end
            default: ;
        endcase
        // r0 is hard-wired zero, so a write to it is dropped
        if (d_wr == 2'd0) d_regwrite = 1'b0;
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [3:1] busy;
    logic [3:0] busy_ext;
    logic [3:1] set_mask, clr_mask;
    logic       pend_rs, pend_rt;

    assign busy_ext = {busy, 1'b0};
    assign pend_rs  = busy_ext[rs] || (out_valid && regwrite && wr == rs);
    assign pend_rt  = busy_ext[rt] || (out_valid && regwrite && wr == rt);
    assign hazard   = in_valid && ((use_rs && rs != 2'd0 && pend_rs) ||
                                   (use_rt && rt != 2'd0 && pend_rt));

    assign clr_mask = {wb_reg == 2'd3, wb_reg == 2'd2, wb_reg == 2'd1} & {3{wb_done}};
    assign set_mask = {wr == 2'd3, wr == 2'd2, wr == 2'd1} & {3{out_valid && out_ready && regwrite}};

    // Set is applied after clear so a same-cycle set wins
    always_ff @(posedge clock) begin
        if (reset) begin
            busy        <= 3'b000;
            stall_count <= 8'd0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (hazard && stall_count != 8'hFF) stall_count <= stall_count + 8'd1;
        end
    end
`else
    logic unused_sb;
    assign unused_sb   = ^{wb_done, wb_reg, use_rs, use_rt};
    assign hazard      = 1'b0;
    assign stall_count = 8'd0;
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            rr1 <= 2'd0; rr2 <= 2'd0; wr <= 2'd0; regwrite <= 1'b0;
            alu_op <= 3'b000; alu_src <= 1'b0; mem_read <= 1'b0;
            mem_write <= 1'b0; branch <= 1'b0; imm <= 16'd0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            rr1 <= d_rr1; rr2 <= d_rr2; wr <= d_wr; regwrite <= d_regwrite;
            alu_op <= d_alu_op; alu_src <= d_alu_src; mem_read <= d_mem_read;
            mem_write <= d_mem_write; branch <= d_branch;
            imm <= {{8{instr[7]}}, instr[7:0]};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized bench for instr_decode_stage against a cycle-level reference model;
// the model follows DECODE_SCOREBOARD_EN the same way the design does.
module tb_instr_decode_stage;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] instr, imm;
    logic [1:0]  rr1, rr2, wr, wb_reg;
    logic        regwrite, alu_src, mem_read, mem_write, branch, wb_done;
    logic [2:0]  alu_op;
    logic [7:0]  stall_count;

    instr_decode_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .rr1(rr1), .rr2(rr2), .wr(wr), .regwrite(regwrite), .alu_op(alu_op),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .imm(imm), .wb_done(wb_done), .wb_reg(wb_reg),
        .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  rr1, rr2, wr;
        logic        regwrite;
        logic [2:0]  alu_op;
        logic        alu_src, mem_read, mem_write, branch;
        logic [15:0] imm;
    } bundle_t;

    int      checks = 0;
    int      errors = 0;
    bit      model_ok = 0;
    bit      m_valid;
    bundle_t m_b;
    bit      m_busy [4];
    int      m_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the opcode table
    function automatic bundle_t ref_decode(input logic [15:0] i, output bit rd_rs, output bit rd_rt);
        bundle_t b;
        int o, s, t, d;
        o = int'(i[15:12]); s = int'(i[11:10]); t = int'(i[9:8]); d = int'(i[7:6]);
        b = '0;
        rd_rs = 0; rd_rt = 0;
        b.imm = 16'(signed'(i[7:0]));
        if (o inside {0, 1, 2, 3, 7}) begin
            b.rr1 = 2'(s); b.rr2 = 2'(t); b.wr = 2'(d); b.regwrite = 1;
            rd_rs = 1; rd_rt = 1;
            b.alu_op = (o == 0) ? 3'd2 : (o == 1) ? 3'd6 : (o == 2) ? 3'd0 : (o == 3) ? 3'd1 : 3'd7;
        end else if (o == 4 || o == 5) begin
            b.rr1 = 2'(s); b.wr = 2'(t); b.regwrite = 1; b.alu_src = 1; b.alu_op = 3'd2;
            b.mem_read = (o == 5); rd_rs = 1;
        end else if (o == 6) begin
            b.rr1 = 2'(s); b.rr2 = 2'(t); b.mem_write = 1; b.alu_src = 1; b.alu_op = 3'd2;
            rd_rs = 1; rd_rt = 1;
        end else if (o == 8) begin
            b.rr1 = 2'(s); b.rr2 = 2'(t); b.branch = 1; b.alu_op = 3'd6;
            rd_rs = 1; rd_rt = 1;
        end
        if (b.wr == 0) b.regwrite = 0;
        return b;
    endfunction

    function automatic bit reg_pending(input int r);
        if (r == 0) return 0;
        return m_busy[r] || (m_valid && m_b.regwrite && int'(m_b.wr) == r);
    endfunction

    // Drive one cycle from a negedge, check, then advance the model at the posedge
    task automatic step(input bit iv, input logic [15:0] ins, input bit ordy,
                        input bit wbd, input logic [1:0] wbr, input bit rst);
        bundle_t nb;
        bit ur, ut, hz, rdy;
        reset = rst; in_valid = iv; instr = ins; out_ready = ordy; wb_done = wbd; wb_reg = wbr;
        nb = ref_decode(ins, ur, ut);
        hz = 0;
`ifdef DECODE_SCOREBOARD_EN
        hz = iv && ((ur && reg_pending(int'(ins[11:10]))) || (ut && reg_pending(int'(ins[9:8]))));
`endif
        rdy = (!m_valid || ordy) && !hz;
        #1;
        if (model_ok) begin
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("bundle", 32'({rr1, rr2, wr, regwrite, alu_op, alu_src, mem_read, mem_write, branch, imm}), 32'(m_b));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
        end
        @(posedge clock);
        if (rst) begin
            m_valid = 0; m_b = '0; m_stall = 0; model_ok = 1;
            foreach (m_busy[k]) m_busy[k] = 0;
        end else begin
            if (hz && m_stall < 255) m_stall++;
`ifdef DECODE_SCOREBOARD_EN
            if (wbd && wbr != 0) m_busy[wbr] = 0;
            if (m_valid && ordy && m_b.regwrite) m_busy[m_b.wr] = 1;
`endif
            if (iv && rdy) begin
                m_valid = 1; m_b = nb;
            end else if (ordy) m_valid = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1; in_valid = 0; instr = '0; out_ready = 0; wb_done = 0; wb_reg = '0;
        @(negedge clock);
        step(0, 16'h0, 0, 0, 2'd0, 1);
        step(0, 16'h0, 0, 0, 2'd0, 1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall", 32'(stall_count), 32'd0);

        // add r3 = r1 + r2
        step(1, 16'h06C0, 1, 0, 2'd0, 0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_addr", 32'({rr1, rr2, wr}), 32'({2'd1, 2'd2, 2'd3}));
        chk("add_ctl", 32'({regwrite, alu_op}), 32'({1'b1, 3'b010}));
        // addi r2 = r1 + 0xFE
        step(1, 16'h46FE, 1, 0, 2'd0, 0);
        chk("addi_imm", 32'(imm), 32'hFFFE);
        chk("addi_ctl", 32'({alu_src, wr, regwrite}), 32'({1'b1, 2'd2, 1'b1}));
        // add with rd=0 drops the write
        step(1, 16'h0500, 1, 0, 2'd0, 0);
        chk("rd0_regwrite", 32'(regwrite), 32'd0);
        step(0, 16'h0, 1, 1, 2'd2, 0);
        step(0, 16'h0, 1, 1, 2'd3, 0);

        // Backpressure: hold "and r2" for 3 cycles, then back-to-back transfer
        step(1, 16'h2580, 0, 0, 2'd0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'h0500, 0, 0, 2'd0, 0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_bundle", 32'({out_valid, wr, alu_op}), 32'({1'b1, 2'd2, 3'b000}));
        end
        step(1, 16'h0500, 1, 0, 2'd0, 0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_bundle", 32'({wr, alu_op, regwrite}), 32'({2'd0, 3'b010, 1'b0}));
        step(0, 16'h0, 1, 1, 2'd2, 0);

        // lw r2, then add reading r2 stalls until writeback of r2
        step(1, 16'h5604, 1, 0, 2'd0, 0);
        step(1, 16'h09C0, 1, 0, 2'd0, 0);
        step(1, 16'h09C0, 1, 0, 2'd0, 0);
`ifdef DECODE_SCOREBOARD_EN
        chk("raw_in_ready", 32'(in_ready), 32'd0);
        chk("raw_stall", 32'(stall_count), 32'd2);
`endif
        step(1, 16'h09C0, 1, 1, 2'd2, 0);
        step(1, 16'h09C0, 1, 0, 2'd0, 0);
        chk("raw_accept", 32'({out_valid, wr}), 32'({1'b1, 2'd3}));

        // Bundle writing r3 leaves while wb clears r3: busy[3] must stay set
        step(1, 16'h0000, 1, 1, 2'd3, 0);
        step(1, 16'h0F00, 0, 0, 2'd0, 0);
        step(1, 16'h0F00, 0, 0, 2'd0, 0);
`ifdef DECODE_SCOREBOARD_EN
        chk("setwins_in_ready", 32'(in_ready), 32'd0);
`endif
        step(1, 16'h0F00, 0, 0, 2'd0, 1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_stall", 32'(stall_count), 32'd0);
        step(1, 16'h0F00, 0, 0, 2'd0, 0);
        chk("midrst_accept", 32'(out_valid), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 in_valid  input  1  upstream instruction valid; in_ready  output  1  stage can accept instr this cycle.
REQ-003 instr  input  16  instruction: op[15:12], rs[11:10], rt[9:8], rd[7:6], imm8[7:0].
REQ-004 out_valid  output  1  decoded bundle valid; out_ready  input  1  register-file/ALU side accepts bundle.
REQ-005 rr1, rr2, wr  output  2 each  register-file read/write addresses; regwrite  output  1  write enable.
REQ-006 alu_op  output  3; alu_src  output  1 (1 = imm); mem_read, mem_write, branch  output  1 each; imm  output  16  sign-extended imm8.
REQ-007 wb_done  input  1  writeback complete pulse; wb_reg  input  2  register written back.
REQ-008 stall_count  output  8  saturating count of hazard-stall cycles.

Function
REQ-009 Transfer in: in_valid && in_ready at a clock edge; transfer out: out_valid && out_ready at a clock edge.
REQ-010 One output register stage; decode latency is exactly 1 cycle from transfer in to out_valid=1.
REQ-011 in_ready = (!out_valid || out_ready) && !hazard; in_ready SHALL NOT depend on in_valid.
REQ-012 Transfer in and transfer out in the same cycle SHALL load the new bundle with no bubble.
REQ-013 While out_valid=1 && out_ready=0, all outputs SHALL hold stable.
REQ-014 R-type (op 0000 add, 0001 sub, 0010 and, 0011 or, 0111 slt): rr1=rs, rr2=rt, wr=rd, regwrite=1, alu_src=0.
REQ-015 alu_op: add/addi/lw/sw 010, sub/beq 110, and 000, or 001, slt 111.
REQ-016 0100 addi, 0101 lw: rr1=rs, wr=rt, regwrite=1, alu_src=1; lw also sets mem_read=1.
REQ-017 0110 sw: rr1=rs, rr2=rt, regwrite=0, mem_write=1, alu_src=1; 1000 beq: rr1=rs, rr2=rt, branch=1, regwrite=0.
REQ-018 Unlisted opcodes SHALL decode as NOP: every control output 0 and all addresses 0.
REQ-019 Any instruction with a resolved wr of 0 SHALL force regwrite=0, since r0 is hard-wired zero.
REQ-020 imm = {{8{imm8[7]}}, imm8} for every opcode.
REQ-021 A busy[3:1] scoreboard SHALL set busy[wr] on transfer out when regwrite=1.
REQ-022 wb_done=1 SHALL clear busy[wb_reg]; wb_reg=0 is ignored.
REQ-023 If a set and a clear of the same register occur in one cycle, the set SHALL win.
REQ-024 hazard=1 when in_valid=1 and a source actually read by the incoming opcode (non-zero) matches either a set busy bit or the held bundle's wr while out_valid && regwrite.
REQ-025 hazard SHALL use registered busy bits only, with no same-cycle bypass from wb_done.
REQ-026 stall_count SHALL increment on every cycle with in_valid && hazard and saturate at 255.

Reset
REQ-027 On reset: out_valid=0, busy=000, stall_count=0, and every decoded output 0; in_ready=1 in the first cycle after reset deasserts.
REQ-028 A reset asserted mid-stall or with a bundle held SHALL discard that bundle and clear the scoreboard in the same edge.

Configuration
REQ-029 Macro DECODE_SCOREBOARD_EN defined: REQ-021..REQ-026 apply.
REQ-030 Macro DECODE_SCOREBOARD_EN undefined: no scoreboard, hazard is tied to 0, stall_count is tied to 0, and wb_done/wb_reg are ignored.

Verification
REQ-031 Reset, then instr=0x0_6C0 (add rs=1 rt=2 rd=3) with out_ready=1 -> next cycle out_valid=1, rr1=1, rr2=2, wr=3, regwrite=1, alu_op=010.
REQ-032 addi rs=1 rt=2 imm8=0xFE -> imm=0xFFFE, alu_src=1, wr=2, regwrite=1; add with rd=0 -> regwrite=0.
REQ-033 out_ready=0 for 3 cycles with a bundle held -> outputs stable and in_ready=0; then out_ready=1 together with a new in_valid -> back-to-back transfer with no bubble.
REQ-034 (EN) Issue lw to r2, then add with rs=2 -> in_ready=0 and stall_count increments each cycle; wb_done=1, wb_reg=2 -> add accepted on the next cycle.
REQ-035 (EN) wb_done for r3 in the same cycle an add with rd=3 transfers out -> busy[3] stays 1; reset asserted during a stall -> busy=000, out_valid=0, stall_count=0.
